test_exit_monitor: RTL

//  Harness-side end of the top-level pass/fail protocol: produces the success and failure

---
 rtl/test_exit_pkg.sv | 24 ++
 rtl/test_exit_con_fifo.sv | 47 ++++
 rtl/test_exit_monitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/test_exit_pkg.sv
// Shared types and constants for the tohost exit monitor: FSM states, device/command
// codes, exit codes and the tohost word classifier.
package test_exit_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_e;

  typedef enum logic [1:0] {K_EXIT, K_PUTC, K_BAD} cmd_kind_e;

  localparam logic [7:0]  DEV_SYS     = 8'd0;
  localparam logic [7:0]  DEV_CON     = 8'd1;
  localparam logic [7:0]  CMD_PUTC    = 8'd1;
  localparam logic [31:0] EXIT_BADCMD = 32'hFFFF_FFFE;
  localparam logic [31:0] EXIT_WDOG   = 32'hFFFF_FFFF;

  function automatic cmd_kind_e decode_kind(input logic [63:0] bits);
    if (bits[63:56] == DEV_SYS && bits[0])
      return K_EXIT;
    else if (bits[63:56] == DEV_CON && bits[55:48] == CMD_PUTC)
      return K_PUTC;
    else
      return K_BAD;
  endfunction

endpackage

// File: rtl/test_exit_con_fifo.sv
// Synchronous first-word-fall-through byte FIFO for console output.
// Only the pointers are reset; the storage array is plain data.
module test_exit_con_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/test_exit_monitor.sv
// Harness-side pass/fail monitor: sinks tohost words, decodes exit/putchar, buffers
// console bytes, runs a progress watchdog and delays success until the console drains.
module test_exit_monitor
  import test_exit_pkg::*;
#(
  parameter int CON_DEPTH    = 4,
  parameter int DRAIN_CYCLES = 16,
  parameter int WDOG_CYCLES  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tohost_valid,
  output logic        tohost_ready,
  input  logic [63:0] tohost_bits,
  input  logic        progress,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_bits,
  output logic        io_success,
  output logic        io_failure,
  output logic [31:0] io_exit_code
);

  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] WDOG_LAST  = (WDOG_CYCLES > 0) ? 32'(WDOG_CYCLES - 1) : 32'd0;
  localparam logic        WDOG_ON    = (WDOG_CYCLES > 0);

  state_e      r_state;
  logic        r_live;
  logic [31:0] r_drain_cnt;
  logic [31:0] r_wdog_cnt;
  logic [31:0] r_fail_code;
  logic        r_success;
  logic        r_failure;
  logic [31:0] r_exit_code;

  logic        w_full;
  logic        w_empty;
  logic        w_xfer;
  logic        w_push;
  logic        w_pop;
  logic        w_wdog_expire;
  cmd_kind_e   w_kind;
  logic [31:0] w_code;

  // r_live keeps ready low while reset is held, since state alone reads RUN then.
  assign tohost_ready  = r_live && (r_state == RUN) && !w_full;
  assign w_xfer        = tohost_valid && tohost_ready;
  assign w_kind        = decode_kind(tohost_bits);
  assign w_code        = tohost_bits[32:1];
  assign w_push        = w_xfer && (w_kind == K_PUTC);
  assign con_valid     = !w_empty;
  assign w_pop         = con_valid && con_ready;
  assign w_wdog_expire = WDOG_ON && (r_state == RUN) && (r_wdog_cnt == WDOG_LAST) && !progress;

  assign io_success   = r_success;
  assign io_failure   = r_failure;
  assign io_exit_code = r_exit_code;

  test_exit_con_fifo #(
    .DEPTH  (CON_DEPTH),
    .DATA_W (8)
  ) u_con_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (tohost_bits[7:0]),
    .i_pop   (w_pop),
    .o_data  (con_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RUN;
      r_live      <= 1'b0;
      r_drain_cnt <= '0;
      r_wdog_cnt  <= '0;
      r_fail_code <= '0;
      r_success   <= 1'b0;
      r_failure   <= 1'b0;
      r_exit_code <= '0;
    end else begin
      r_live      <= 1'b1;
      r_success   <= (r_state == PASS);
      r_failure   <= (r_state == FAIL);
      r_exit_code <= (r_state == FAIL) ? r_fail_code : 32'd0;

      case (r_state)
        RUN: begin
          // A transfer in the same cycle as watchdog expiry is decoded, not failed.
          if (w_xfer) begin
            case (w_kind)
              K_EXIT: begin
                if (w_code == 32'd0) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= '0;
                end else begin
                  r_state     <= FAIL;
                  r_fail_code <= w_code;
                end
              end
              K_PUTC: ;
              default: begin
                r_state     <= FAIL;
                r_fail_code <= EXIT_BADCMD;
              end
            endcase
          end else if (w_wdog_expire) begin
            r_state     <= FAIL;
            r_fail_code <= EXIT_WDOG;
          end
          if (WDOG_ON)
            r_wdog_cnt <= (w_xfer || progress) ? 32'd0 : r_wdog_cnt + 32'd1;
        end
        DRAIN: begin
          if (r_drain_cnt >= DRAIN_LAST && w_empty)
            r_state <= PASS;
          else if (r_drain_cnt < DRAIN_LAST)
            r_drain_cnt <= r_drain_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
